// File: rtl/obi_id_mux_idx_fifo.sv
// -----------------------------------------------------------------------------
// obi_id_mux_idx_fifo
// Small index FIFO that remembers which port each outstanding transaction
// belongs to, so in-order responses can be steered back to the right port.
// Synchronous active-low reset. Registered head only: a pushed entry becomes
// visible at data_o on the next cycle at the earliest.
//
// Ports:
//   clk_i    clock
//   rst_ni   synchronous active-low reset
//   push_i   write data_i at the tail (ignored while full)
//   data_i   port index to store
//   pop_i    drop the head entry (ignored while empty)
//   data_o   head entry
//   empty_o  no entries stored
//   full_o   DEPTH entries stored
// -----------------------------------------------------------------------------
module obi_id_mux_idx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam logic [CntW-1:0] MaxCnt  = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_cnt;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (r_cnt == {CntW{1'b0}});
  assign full_o  = (r_cnt == MaxCnt);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rptr];

  // Storage, pointers and occupancy; simultaneous push and pop keeps occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wptr <= {PtrW{1'b0}};
      r_rptr <= {PtrW{1'b0}};
      r_cnt  <= {CntW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= (r_wptr == LastPtr) ? {PtrW{1'b0}} : r_wptr + PtrW'(1);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LastPtr) ? {PtrW{1'b0}} : r_rptr + PtrW'(1);
      end else begin
        r_rptr <= r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/obi_id_mux.sv
// -----------------------------------------------------------------------------
// obi_id_mux
// N:1 OBI request multiplexer. Requests from NumSlvPorts managers are
// arbitrated (round-robin or fixed priority) onto one subordinate port.
// Responses are routed back either in order (index FIFO, RouteById=0) or by
// the port index carried in the upper ID bits (RouteById=1). Outstanding
// transactions are capped: one shared cap in FIFO mode, one cap per port in
// ID mode. Synchronous active-low reset.
//
// Ports:
//   clk_i, rst_ni                     clock, synchronous active-low reset
//   slv_req_i / slv_gnt_o             per-port A-channel request / grant
//   slv_addr_i, slv_we_i, slv_be_i,
//   slv_wdata_i, slv_aid_i            per-port A-channel payload (packed)
//   slv_rvalid_o / slv_rready_i       per-port response valid / ready
//   slv_rdata_o, slv_rid_o, slv_err_o response payload broadcast to all ports
//   mst_req_o / mst_gnt_i             muxed A-channel request / grant
//   mst_addr_o, mst_we_o, mst_be_o,
//   mst_wdata_o, mst_aid_o            payload of the selected port
//   mst_rvalid_i / mst_rready_o       response valid / ready
//   mst_rdata_i, mst_rid_i, mst_err_i response payload
//   unexp_rsp_o                       response with no outstanding transaction
// -----------------------------------------------------------------------------
module obi_id_mux #(
  parameter int unsigned NumSlvPorts  = 4,
  parameter int unsigned NumMaxTrans  = 4,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned SlvIdWidth   = 1,
  parameter bit          RouteById    = 1'b1,
  parameter bit          ArbFixedPrio = 1'b0,
  parameter bit          UseRReady    = 1'b0,
  localparam int unsigned PortIdxW    = $clog2(NumSlvPorts),
  localparam int unsigned MstIdWidth  = RouteById ? (SlvIdWidth + PortIdxW) : SlvIdWidth,
  localparam int unsigned BeWidth     = DataWidth / 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumSlvPorts-1:0]            slv_req_i,
  output logic [NumSlvPorts-1:0]            slv_gnt_o,
  input  logic [NumSlvPorts*AddrWidth-1:0]  slv_addr_i,
  input  logic [NumSlvPorts-1:0]            slv_we_i,
  input  logic [NumSlvPorts*BeWidth-1:0]    slv_be_i,
  input  logic [NumSlvPorts*DataWidth-1:0]  slv_wdata_i,
  input  logic [NumSlvPorts*SlvIdWidth-1:0] slv_aid_i,
  output logic [NumSlvPorts-1:0]            slv_rvalid_o,
  input  logic [NumSlvPorts-1:0]            slv_rready_i,
  output logic [DataWidth-1:0]              slv_rdata_o,
  output logic [SlvIdWidth-1:0]             slv_rid_o,
  output logic                              slv_err_o,
  output logic                              mst_req_o,
  input  logic                              mst_gnt_i,
  output logic [AddrWidth-1:0]              mst_addr_o,
  output logic                              mst_we_o,
  output logic [BeWidth-1:0]                mst_be_o,
  output logic [DataWidth-1:0]              mst_wdata_o,
  output logic [MstIdWidth-1:0]             mst_aid_o,
  input  logic                              mst_rvalid_i,
  output logic                              mst_rready_o,
  input  logic [DataWidth-1:0]              mst_rdata_i,
  input  logic [MstIdWidth-1:0]             mst_rid_i,
  input  logic                              mst_err_i,
  output logic                              unexp_rsp_o
);

  if (NumSlvPorts < 2 || NumSlvPorts > 32) begin : g_bad_ports
    $fatal(1, "obi_id_mux: NumSlvPorts must be within 2..32");
  end
  if (NumMaxTrans < 1) begin : g_bad_trans
    $fatal(1, "obi_id_mux: NumMaxTrans must be at least 1");
  end
  if (SlvIdWidth < 1) begin : g_bad_id
    $fatal(1, "obi_id_mux: SlvIdWidth must be at least 1");
  end

  localparam int unsigned     CntW    = $clog2(NumMaxTrans + 1);
  localparam logic [PortIdxW-1:0] LastIdx = PortIdxW'(NumSlvPorts - 1);

  logic [NumSlvPorts-1:0] w_full;
  logic [NumSlvPorts-1:0] w_elig;
  logic [PortIdxW-1:0]    r_rr_ptr;
  logic [PortIdxW-1:0]    r_lock_idx;
  logic                   r_lock;
  logic [PortIdxW-1:0]    w_arb_idx;
  logic                   w_arb_found;
  logic [PortIdxW-1:0]    w_sel;
  logic                   w_hs;
  logic [PortIdxW-1:0]    w_tgt;
  logic                   w_known;
  logic                   w_rready;
  logic                   w_rsp_hs;

  assign w_elig = slv_req_i & ~w_full;

  // Arbiter: first eligible index scanning upward from the start point, wrapping.
  always_comb begin
    int idx;
    w_arb_found = 1'b0;
    w_arb_idx   = {PortIdxW{1'b0}};
    idx         = 0;
    for (int k = 0; k < int'(NumSlvPorts); k++) begin
      idx = ((ArbFixedPrio ? 0 : int'(r_rr_ptr)) + k) % int'(NumSlvPorts);
      if (!w_arb_found && w_elig[idx]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = PortIdxW'(idx);
      end else begin
        w_arb_found = w_arb_found;
      end
    end
  end

  // A stalled request keeps its port so the payload stays stable until granted.
  assign w_sel     = r_lock ? r_lock_idx : w_arb_idx;
  assign mst_req_o = rst_ni & (r_lock | w_arb_found);
  assign w_hs      = mst_req_o & mst_gnt_i;

  assign mst_addr_o  = slv_addr_i[w_sel*AddrWidth +: AddrWidth];
  assign mst_we_o    = slv_we_i[w_sel];
  assign mst_be_o    = slv_be_i[w_sel*BeWidth +: BeWidth];
  assign mst_wdata_o = slv_wdata_i[w_sel*DataWidth +: DataWidth];

  if (RouteById) begin : g_aid_id
    assign mst_aid_o = {w_sel, slv_aid_i[w_sel*SlvIdWidth +: SlvIdWidth]};
  end else begin : g_aid_fifo
    assign mst_aid_o = slv_aid_i[w_sel*SlvIdWidth +: SlvIdWidth];
  end

  // Grant goes back to the selected port in the handshake cycle only.
  always_comb begin
    slv_gnt_o = {NumSlvPorts{1'b0}};
    if (w_hs) begin
      slv_gnt_o[w_sel] = 1'b1;
    end else begin
      slv_gnt_o = {NumSlvPorts{1'b0}};
    end
  end

  // Round-robin pointer and request lock.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr_ptr   <= {PortIdxW{1'b0}};
      r_lock     <= 1'b0;
      r_lock_idx <= {PortIdxW{1'b0}};
    end else if (w_hs) begin
      r_rr_ptr   <= (w_sel == LastIdx) ? {PortIdxW{1'b0}} : w_sel + PortIdxW'(1);
      r_lock     <= 1'b0;
      r_lock_idx <= r_lock_idx;
    end else if (mst_req_o) begin
      r_rr_ptr   <= r_rr_ptr;
      r_lock     <= 1'b1;
      r_lock_idx <= w_sel;
    end else begin
      r_rr_ptr   <= r_rr_ptr;
      r_lock     <= r_lock;
      r_lock_idx <= r_lock_idx;
    end
  end

  // Responses without a matching outstanding transaction are always accepted
  // and dropped so a stray beat cannot wedge the subordinate.
  assign w_rready     = UseRReady ? slv_rready_i[w_tgt] : 1'b1;
  assign mst_rready_o = rst_ni ? (w_known ? w_rready : 1'b1) : !UseRReady;
  assign w_rsp_hs     = rst_ni & mst_rvalid_i & w_known & w_rready;
  assign unexp_rsp_o  = rst_ni & mst_rvalid_i & ~w_known;
  assign slv_rdata_o  = rst_ni ? mst_rdata_i : {DataWidth{1'b0}};
  assign slv_rid_o    = rst_ni ? mst_rid_i[SlvIdWidth-1:0] : {SlvIdWidth{1'b0}};
  assign slv_err_o    = rst_ni & mst_err_i;

  // Response valid is steered to the target port only.
  always_comb begin
    slv_rvalid_o = {NumSlvPorts{1'b0}};
    if (rst_ni && mst_rvalid_i && w_known) begin
      slv_rvalid_o[w_tgt] = 1'b1;
    end else begin
      slv_rvalid_o = {NumSlvPorts{1'b0}};
    end
  end

  if (RouteById) begin : g_id_mode
    localparam logic [CntW-1:0] MaxCnt = CntW'(NumMaxTrans);
    logic [CntW-1:0] r_cnt [NumSlvPorts];

    assign w_tgt   = mst_rid_i[MstIdWidth-1 -: PortIdxW];
    assign w_known = (32'(w_tgt) < NumSlvPorts) && (r_cnt[w_tgt] != {CntW{1'b0}});

    for (genvar g = 0; g < int'(NumSlvPorts); g++) begin : g_full
      assign w_full[g] = (r_cnt[g] == MaxCnt);
    end

    // Per-port outstanding counters; grant and response together cancel out.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(NumSlvPorts); i++) begin
          r_cnt[i] <= {CntW{1'b0}};
        end
      end else begin
        for (int i = 0; i < int'(NumSlvPorts); i++) begin
          case ({w_hs && (w_sel == PortIdxW'(i)), w_rsp_hs && (w_tgt == PortIdxW'(i))})
            2'b10:   r_cnt[i] <= r_cnt[i] + CntW'(1);
            2'b01:   r_cnt[i] <= r_cnt[i] - CntW'(1);
            default: r_cnt[i] <= r_cnt[i];
          endcase
        end
      end
    end
  end else begin : g_fifo_mode
    logic w_empty;
    logic w_ff_full;

    obi_id_mux_idx_fifo #(
      .DEPTH (NumMaxTrans),
      .WIDTH (PortIdxW)
    ) i_idx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_hs),
      .data_i  (w_sel),
      .pop_i   (w_rsp_hs),
      .data_o  (w_tgt),
      .empty_o (w_empty),
      .full_o  (w_ff_full)
    );

    assign w_known = !w_empty;
    // One shared cap: a full FIFO stalls every port.
    assign w_full  = {NumSlvPorts{w_ff_full}};
  end

endmodule

// File: tb/tb_obi_id_mux.sv
// -----------------------------------------------------------------------------
// tb_obi_id_mux
// Directed bench with two instances:
//   A: ID mode, round-robin, NumMaxTrans=2, rready ignored
//   B: FIFO mode, fixed priority, NumMaxTrans=3, rready honoured
// -----------------------------------------------------------------------------
module tb_obi_id_mux;

  logic clk;
  logic a_rst_n, b_rst_n;

  // Instance A signals
  logic [3:0]   a_req, a_gnt, a_we, a_rvalid, a_rready, a_aid;
  logic [127:0] a_addr, a_wdata;
  logic [15:0]  a_be;
  logic [31:0]  a_rdata, a_maddr, a_mwdata, a_mrdata;
  logic [0:0]   a_rid;
  logic         a_err, a_mreq, a_mgnt, a_mwe, a_mrvalid, a_mrready, a_merr, a_unexp;
  logic [3:0]   a_mbe;
  logic [2:0]   a_maid, a_mrid;

  // Instance B signals
  logic [3:0]   b_req, b_gnt, b_we, b_rvalid, b_rready, b_aid;
  logic [127:0] b_addr, b_wdata;
  logic [15:0]  b_be;
  logic [31:0]  b_rdata, b_maddr, b_mwdata, b_mrdata;
  logic [0:0]   b_rid;
  logic         b_err, b_mreq, b_mgnt, b_mwe, b_mrvalid, b_mrready, b_merr, b_unexp;
  logic [3:0]   b_mbe;
  logic [0:0]   b_maid, b_mrid;

  int checks   = 0;
  int failures = 0;

  obi_id_mux #(
    .NumSlvPorts(4), .NumMaxTrans(2), .AddrWidth(32), .DataWidth(32), .SlvIdWidth(1),
    .RouteById(1'b1), .ArbFixedPrio(1'b0), .UseRReady(1'b0)
  ) dut_a (
    .clk_i(clk), .rst_ni(a_rst_n),
    .slv_req_i(a_req), .slv_gnt_o(a_gnt), .slv_addr_i(a_addr), .slv_we_i(a_we),
    .slv_be_i(a_be), .slv_wdata_i(a_wdata), .slv_aid_i(a_aid),
    .slv_rvalid_o(a_rvalid), .slv_rready_i(a_rready), .slv_rdata_o(a_rdata),
    .slv_rid_o(a_rid), .slv_err_o(a_err),
    .mst_req_o(a_mreq), .mst_gnt_i(a_mgnt), .mst_addr_o(a_maddr), .mst_we_o(a_mwe),
    .mst_be_o(a_mbe), .mst_wdata_o(a_mwdata), .mst_aid_o(a_maid),
    .mst_rvalid_i(a_mrvalid), .mst_rready_o(a_mrready), .mst_rdata_i(a_mrdata),
    .mst_rid_i(a_mrid), .mst_err_i(a_merr), .unexp_rsp_o(a_unexp)
  );

  obi_id_mux #(
    .NumSlvPorts(4), .NumMaxTrans(3), .AddrWidth(32), .DataWidth(32), .SlvIdWidth(1),
    .RouteById(1'b0), .ArbFixedPrio(1'b1), .UseRReady(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_ni(b_rst_n),
    .slv_req_i(b_req), .slv_gnt_o(b_gnt), .slv_addr_i(b_addr), .slv_we_i(b_we),
    .slv_be_i(b_be), .slv_wdata_i(b_wdata), .slv_aid_i(b_aid),
    .slv_rvalid_o(b_rvalid), .slv_rready_i(b_rready), .slv_rdata_o(b_rdata),
    .slv_rid_o(b_rid), .slv_err_o(b_err),
    .mst_req_o(b_mreq), .mst_gnt_i(b_mgnt), .mst_addr_o(b_maddr), .mst_we_o(b_mwe),
    .mst_be_o(b_mbe), .mst_wdata_o(b_mwdata), .mst_aid_o(b_maid),
    .mst_rvalid_i(b_mrvalid), .mst_rready_o(b_mrready), .mst_rdata_i(b_mrdata),
    .mst_rid_i(b_mrid), .mst_err_i(b_merr), .unexp_rsp_o(b_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  rr_gnt_exp  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [2:0]  rr_aid_exp  [5] = '{3'b000, 3'b011, 3'b100, 3'b111, 3'b000};
  logic [31:0] rr_addr_exp [5] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002,
                                   32'hA000_0003, 32'hA000_0000};
  logic [2:0]  dr_rid      [5] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};
  logic [3:0]  dr_rv_exp   [5] = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_addr  = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    b_addr  = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
    a_wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    b_wdata = a_wdata;
    a_be = 16'h8421; b_be = 16'h8421;
    a_we = 4'b0101;  b_we = 4'b0101;
    a_aid = 4'b1010; b_aid = 4'b0110;
    a_rready = 4'hF; b_rready = 4'hF;
    a_req = 4'hF; b_req = 4'hF;
    a_mgnt = 1'b1; b_mgnt = 1'b1;
    a_mrvalid = 1'b1; b_mrvalid = 1'b1;
    a_mrdata = 32'h0; b_mrdata = 32'h0;
    a_mrid = 3'b000; b_mrid = 1'b0;
    a_merr = 1'b1; b_merr = 1'b1;

    // Outputs held quiet while in reset, even with requests and responses pending
    tick(); tick();
    chk("a_rst_req", a_mreq, 1'b0);
    chk("a_rst_gnt", a_gnt, 4'b0000);
    chk("a_rst_rvalid", a_rvalid, 4'b0000);
    chk("a_rst_rready", a_mrready, 1'b1);
    chk("a_rst_unexp", a_unexp, 1'b0);
    chk("a_rst_err", a_err, 1'b0);
    chk("b_rst_req", b_mreq, 1'b0);
    chk("b_rst_gnt", b_gnt, 4'b0000);
    chk("b_rst_rready", b_mrready, 1'b0);
    chk("b_rst_unexp", b_unexp, 1'b0);

    // A: round-robin rotation with all ports requesting
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    a_mrvalid = 1'b0; b_mrvalid = 1'b0; b_req = 4'b0000;
    a_merr = 1'b0; b_merr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("a_rr_gnt", a_gnt, rr_gnt_exp[k]);
      chk("a_rr_aid", a_maid, rr_aid_exp[k]);
      chk("a_rr_addr", a_maddr, rr_addr_exp[k]);
      tick();
    end

    // A: drain the five outstanding transactions by ID
    a_req = 4'b0000; a_mgnt = 1'b0; a_mrvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_mrid = dr_rid[k]; a_mrdata = 32'hD000_0000 + 32'(k);
      #1;
      chk("a_rsp_rvalid", a_rvalid, dr_rv_exp[k]);
      chk("a_rsp_rdata", a_rdata, 32'hD000_0000 + 32'(k));
      chk("a_rsp_rid", a_rid, dr_rid[k][0]);
      chk("a_rsp_unexp", a_unexp, 1'b0);
      tick();
    end

    // A: one more response for port 0 has nothing outstanding
    a_mrid = 3'b000;
    #1;
    chk("a_unexp_pulse", a_unexp, 1'b1);
    chk("a_unexp_rvalid", a_rvalid, 4'b0000);
    chk("a_unexp_rready", a_mrready, 1'b1);
    tick();
    a_mrvalid = 1'b0;
    #1;
    chk("a_unexp_end", a_unexp, 1'b0);

    // A: per-port cap of two (rr_ptr is 1 here)
    a_req = 4'b0010; a_mgnt = 1'b1;
    #1; chk("a_cap_g1", a_gnt, 4'b0010); tick();
    #1; chk("a_cap_g2", a_gnt, 4'b0010); tick();
    a_req = 4'b1010;
    #1;
    chk("a_cap_p3", a_gnt, 4'b1000);
    chk("a_cap_p3_aid", a_maid, 3'b111);
    tick();
    a_req = 4'b0010; a_mrvalid = 1'b1; a_mrid = 3'b011;
    #1;
    chk("a_cap_block_req", a_mreq, 1'b0);
    chk("a_cap_block_gnt", a_gnt, 4'b0000);
    chk("a_cap_rsp_rvalid", a_rvalid, 4'b0010);
    chk("a_cap_rsp_rid", a_rid, 1'b1);
    tick();
    a_mrvalid = 1'b0;
    #1; chk("a_cap_reenable", a_gnt, 4'b0010); tick();
    a_req = 4'b0000; a_mrvalid = 1'b1; a_mrid = 3'b010;
    #1; chk("a_p1_rsp", a_rvalid, 4'b0010); tick();
    // Grant and response to port 1 in the same cycle leave its count at 1
    a_req = 4'b0010;
    #1;
    chk("a_same_gnt", a_gnt, 4'b0010);
    chk("a_same_rvalid", a_rvalid, 4'b0010);
    tick();
    a_mrvalid = 1'b0;
    #1; chk("a_same_next_gnt", a_gnt, 4'b0010); tick();
    #1; chk("a_same_full_req", a_mreq, 1'b0);

    // A: reset mid-burst clears all counts
    a_rst_n = 1'b0;
    #1; chk("a_midrst_gnt", a_gnt, 4'b0000);
    tick();
    a_rst_n = 1'b1; a_mrvalid = 1'b1; a_mrid = 3'b111;
    #1;
    chk("a_postrst_gnt", a_gnt, 4'b0010);
    chk("a_postrst_unexp", a_unexp, 1'b1);
    chk("a_postrst_rvalid", a_rvalid, 4'b0000);
    tick();
    a_req = 4'b0000; a_mrvalid = 1'b0;

    // B: lock holds port 2 while port 0 (higher priority) appears
    b_mgnt = 1'b0; b_req = 4'b0100;
    #1;
    chk("b_lock_req", b_mreq, 1'b1);
    chk("b_lock_gnt0", b_gnt, 4'b0000);
    chk("b_lock_addr0", b_maddr, 32'hB000_0002);
    tick();
    b_req = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("b_lock_addr", b_maddr, 32'hB000_0002);
      chk("b_lock_wdata", b_mwdata, 32'h2222_2222);
      chk("b_lock_gnt", b_gnt, 4'b0000);
      tick();
    end
    b_mgnt = 1'b1;
    #1;
    chk("b_lock_release", b_gnt, 4'b0100);
    chk("b_lock_aid", b_maid, 1'b1);
    tick();
    #1;
    chk("b_after_lock", b_gnt, 4'b0001);
    chk("b_after_lock_aid", b_maid, 1'b0);
    chk("b_after_lock_be", b_mbe, 4'h1);
    tick();
    // Fixed priority: port 0 beats port 1 although port 0 was just served
    b_req = 4'b0011;
    #1; chk("b_fixed_prio", b_gnt, 4'b0001); tick();
    // FIFO now holds {2,0,0}: full, every port blocked
    b_req = 4'b1000;
    #1;
    chk("b_full_req", b_mreq, 1'b0);
    chk("b_full_gnt", b_gnt, 4'b0000);
    tick();

    // B: head is port 2, which is not ready for two cycles
    b_mrvalid = 1'b1; b_rready = 4'b1011; b_mrdata = 32'hC000_0000;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("b_bp_rvalid", b_rvalid, 4'b0100);
      chk("b_bp_rready", b_mrready, 1'b0);
      tick();
    end
    b_rready = 4'b1111;
    #1;
    chk("b_pop_rvalid", b_rvalid, 4'b0100);
    chk("b_pop_rready", b_mrready, 1'b1);
    chk("b_pop_rdata", b_rdata, 32'hC000_0000);
    chk("b_pop_still_full", b_mreq, 1'b0);
    tick();
    // Slot freed: port 3 granted while the port-0 response pops
    b_mrdata = 32'hC000_0001; b_merr = 1'b1;
    #1;
    chk("b_pushpop_gnt", b_gnt, 4'b1000);
    chk("b_pushpop_rvalid", b_rvalid, 4'b0001);
    chk("b_pushpop_err", b_err, 1'b1);
    chk("b_pushpop_rdata", b_rdata, 32'hC000_0001);
    tick();
    b_req = 4'b0000; b_merr = 1'b0; b_mrdata = 32'hC000_0002;
    #1;
    chk("b_rsp3_rvalid", b_rvalid, 4'b0001);
    chk("b_rsp3_err", b_err, 1'b0);
    tick();
    b_mrdata = 32'hC000_0003;
    #1;
    chk("b_rsp4_rvalid", b_rvalid, 4'b1000);
    chk("b_rsp4_rdata", b_rdata, 32'hC000_0003);
    tick();
    // FIFO empty: response discarded even with every rready low
    b_rready = 4'b0000;
    #1;
    chk("b_unexp_pulse", b_unexp, 1'b1);
    chk("b_unexp_rvalid", b_rvalid, 4'b0000);
    chk("b_unexp_rready", b_mrready, 1'b1);
    tick();
    b_mrvalid = 1'b0;
    #1;
    chk("b_unexp_end", b_unexp, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
